fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Holds the architectural PC and fetches instructions from instruction memory over a
//  req/gnt + rvalid handshake. Sits between the next-PC logic (which supplies redirect
//  targets) and decode. Sequential PC advance is +4 internally; branches and jumps arrive
//  as redirects. A small FIFO decouples memory latency from decode back-pressure.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  DEPTH     2              instruction FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous active-high reset
//  redirect_valid  in   1   control-flow change this cycle
//  redirect_pc     in   32  new PC (next-PC output)
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address (= pc)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response data valid (>=1 cycle after gnt)
//  imem_rdata      in   32  instruction word
//  inst_valid      out  1   FIFO head valid to decode
//  inst_ready      in   1   decode accepts head
//  inst            out  32  head instruction; 32'h0000_0013 (nop) when empty
//  inst_pc         out  32  PC of head instruction; 0 when empty
//  misalign        out  1   misaligned-redirect flag (feature-dependent)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0 in reset cycle, inst_valid=0, misalign=0.
//  - Max one outstanding memory request. State: IDLE (none), WAIT (awaiting rvalid),
//    DROP (awaiting rvalid of a flushed request; data discarded).
//  - imem_req=1 only in IDLE, when !rst, !redirect_valid, and count<DEPTH (space reserved).
//    imem_addr=pc combinationally, held stable while imem_req && !imem_gnt.
//  - IDLE & req & gnt: req_pc<=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC->0), ->WAIT.
//  - WAIT & rvalid: push {rdata, req_pc}, ->IDLE. Next request may issue the same cycle
//    rvalid arrives only from IDLE, i.e. next cycle (fetch rate 1 per 2 cycles at 1-cycle latency).
//  - DROP & rvalid: discard, ->IDLE.
//  - Pop when inst_valid && inst_ready; push and pop may coincide (count unchanged).
//  - Redirect (highest priority): pc<=redirect_pc, FIFO flushed (pop ignored that cycle),
//    WAIT->DROP; WAIT with rvalid same cycle ->IDLE, data discarded; DROP stays DROP
//    unless rvalid (->IDLE). imem_req forced 0 on redirect cycle, so no gnt race.
//  - Redirect and rst together: rst wins.
//  - rst mid-WAIT: ->IDLE; late rvalid after reset must be ignored -> rst goes to DROP
//    if state was WAIT/DROP, else IDLE (memory never sees a new req until stale rvalid).
//  - inst_valid = count!=0; inst/inst_pc from FIFO head, registered storage.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign=1
//    (sticky until rst or next aligned redirect); while set, imem_req=0; pc still loaded.
//  Undefined: redirect_pc[1:0] forced to 2'b00 when loaded; misalign tied 0.
// TESTING
//  1 rst 2 cycles, gnt=1, 1-cycle rvalid, ready=1 -> addrs 0x0,0x4,0x8; inst_pc matches, inst=rdata.
//  2 ready=0, DEPTH=2 -> two pushes then imem_req=0; ready=1 one cycle -> req reasserts next cycle.
//  3 gnt for 0x8, redirect to 0x100 while WAIT -> 0x8 data dropped; next req addr 0x100, FIFO empty.
//  4 redirect same cycle as rvalid -> data discarded, state IDLE, next req 0x100 following cycle.
//  5 gnt held low 3 cycles -> imem_addr stable 0x4; pc advances only on gnt.
//  6 EN: redirect 0x102 -> misalign=1, imem_req=0; redirect 0x200 -> misalign=0, fetch 0x200.
//    Not EN: redirect 0x102 -> fetch addr 0x100, misalign=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: holds the architectural PC and fetches instruction words over a
// req/gnt + rvalid memory handshake, buffering them in a small FIFO for decode.
// At most one memory request is outstanding at a time.
//
// Build option FETCH_MISALIGN_CHECK_EN:
//   defined   - a redirect to a non-word-aligned PC raises a sticky misalign flag
//               and stalls fetch until reset or the next aligned redirect.
//   undefined - the low two bits of a redirect target are cleared; misalign is 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no request outstanding; may issue a new request
// WAIT   | request granted, awaiting its rvalid (data will be kept)
// DROP   | request granted but flushed; its rvalid is swallowed
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          fire;
  logic          push;
  logic          pop;
  logic          req_block;
  logic [31:0]   redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_tgt = redirect_pc;
  assign req_block    = misalign_q;
  assign misalign     = misalign_q;

  // Sticky misalign flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign req_block    = 1'b0;
  assign misalign     = 1'b0;
`endif

  // Only issue from IDLE with a FIFO slot free; a redirect cycle never requests,
  // so a grant can never race a PC change.
  assign imem_req   = (state == S_IDLE) && !rst && !redirect_valid &&
                      (count < FULL) && !req_block;
  assign imem_addr  = pc;
  assign fire       = imem_req && imem_gnt;
  assign push       = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst       = inst_valid ? fifo_inst[rd_ptr] : NOP;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : 32'h0000_0000;

  // Request-tracking next state; a redirect turns a live request into a dropped one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)         state_nxt = S_IDLE;
        else if (redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: if (imem_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC, state and FIFO control; reset keeps swallowing a response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      state  <= ((state == S_WAIT || state == S_DROP) && !imem_rvalid) ? S_DROP : S_IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc     <= redirect_tgt;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage: request PC capture and FIFO entries need no reset.
  always_ff @(posedge clk) begin
    if (fire) req_pc <= pc;
    if (!rst && push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. A transaction-level reference
// model (PC value, outstanding/flushed request flags, queue of fetched words)
// predicts every output each cycle; a simple memory model answers requests with
// 1-3 cycle latency, including responses that arrive after a flush or reset.
module tb_fetch_unit;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_req_pc = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_mis = 1'b0;
  bit          exp_req;
  bit          mem_pending = 1'b0;
  int          mem_wait = 0;

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0100;
      1:       return 32'h0000_0102;
      2:       return 32'h0000_0200;
      3:       return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || (cyc >= 200 && $urandom_range(0, 79) == 0);
      if (cyc < 40) begin
        imem_gnt       = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
      end else if (cyc < 70) begin
        imem_gnt       = 1'b1;
        inst_ready     = (cyc % 10 == 9);
        redirect_valid = 1'b0;
      end else begin
        imem_gnt       = ($urandom_range(0, 3) != 0);
        inst_ready     = ($urandom_range(0, 2) != 0);
        redirect_valid = ($urandom_range(0, 11) == 0);
      end
      redirect_pc = pick_target();
      imem_rvalid = mem_pending && (mem_wait == 0);
      imem_rdata  = $urandom;
      #1;

      exp_req = !rst && !redirect_valid && !m_busy && !m_stale &&
                (q.size() < DEPTH) && !m_mis;
      if (cyc > 0) begin
        check("imem_req",   {31'h0, imem_req},   {31'h0, exp_req});
        check("imem_addr",  imem_addr,           m_pc);
        check("inst_valid", {31'h0, inst_valid}, {31'h0, q.size() != 0});
        check("inst",       inst,                (q.size() != 0) ? q[0].word : 32'h0000_0013);
        check("inst_pc",    inst_pc,             (q.size() != 0) ? q[0].pc : 32'h0);
        check("misalign",   {31'h0, misalign},   {31'h0, m_mis});
      end

      @(posedge clk);
      if (rst) begin
        m_pc    = 32'h0;
        q.delete();
        m_mis   = 1'b0;
        m_stale = (m_busy || m_stale) && !imem_rvalid;
        m_busy  = 1'b0;
      end else if (redirect_valid) begin
        q.delete();
        m_pc  = EN ? redirect_pc : (redirect_pc & 32'hFFFF_FFFC);
        m_mis = EN && (redirect_pc[1:0] != 2'b00);
        if (imem_rvalid) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else if (m_busy) begin
          m_busy  = 1'b0;
          m_stale = 1'b1;
        end
      end else begin
        if (q.size() != 0 && inst_ready) void'(q.pop_front());
        if (imem_rvalid) begin
          if (m_busy) q.push_back('{word: imem_rdata, pc: m_req_pc});
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end
        if (exp_req && imem_gnt) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
          m_busy   = 1'b1;
        end
      end

      if (imem_rvalid) mem_pending = 1'b0;
      else if (mem_pending && mem_wait > 0) mem_wait--;
      if (exp_req && imem_gnt) begin
        mem_pending = 1'b1;
        mem_wait    = (cyc < 40) ? 0 : $urandom_range(0, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
